// File: rtl/ability_scheduler.sv
// Ability controller for the computer character: arbitrates gate and blackout
// triggers, tracks gate-slot selection/occupancy and runs the per-tick cooldowns.
module ability_scheduler #(
  parameter int NUM_GATES    = 10,
  parameter int IDX_W        = 4,
  parameter int GATE_CD      = 7,
  parameter int BLACKOUT_CD  = 30,
  parameter int BLACKOUT_LEN = 5,
  parameter int CD_W         = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enableDC,
  input  logic                 game_active,
  input  logic                 gate_req,
  input  logic                 blackout_req,
  input  logic                 sel_next,
  input  logic                 sel_back,
  input  logic [NUM_GATES-1:0] gate_clear,
  output logic [IDX_W-1:0]     sel_idx,
  output logic [NUM_GATES-1:0] gates_occupied,
  output logic                 gate_place,
  output logic [IDX_W-1:0]     gate_place_idx,
  output logic                 gate_reject,
  output logic                 blackout_active,
  output logic                 gate_ready,
  output logic                 blackout_ready,
  output logic [CD_W-1:0]      gate_cd,
  output logic [CD_W-1:0]      blackout_cd
);

  localparam logic IDLE     = 1'b0;
  localparam logic BLACKOUT = 1'b1;

  localparam logic [CD_W-1:0]  GATE_CD_V = CD_W'(GATE_CD);
  localparam logic [CD_W-1:0]  BO_CD_V   = CD_W'(BLACKOUT_CD);
  localparam logic [CD_W-1:0]  BO_LEN_V  = CD_W'(BLACKOUT_LEN);
  localparam logic [IDX_W-1:0] SEL_MAX   = IDX_W'(NUM_GATES - 1);
  localparam logic [CD_W-1:0]  CD_ZERO   = '0;
  localparam logic [CD_W-1:0]  CD_ONE    = CD_W'(1);

  logic                 state_q, state_d;
  logic [CD_W-1:0]      bo_timer_q, bo_timer_d;
  logic [CD_W-1:0]      gate_cd_q, gate_cd_d;
  logic [CD_W-1:0]      bo_cd_q, bo_cd_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [NUM_GATES-1:0] occ_q, occ_d;
  logic                 place_q, place_d;
  logic [IDX_W-1:0]     place_idx_q, place_idx_d;
  logic                 reject_q, reject_d;
  logic                 bo_active_q;

  logic gate_acc, bo_acc;

  assign bo_acc   = blackout_req && game_active && (state_q == IDLE) && (bo_cd_q == CD_ZERO);
  // A simultaneous blackout request always pre-empts the gate.
  assign gate_acc = gate_req && game_active && (state_q == IDLE) && (gate_cd_q == CD_ZERO)
                    && !occ_q[sel_q] && !blackout_req;

  always_comb begin
    state_d     = state_q;
    bo_timer_d  = bo_timer_q;
    gate_cd_d   = gate_cd_q;
    bo_cd_d     = bo_cd_q;
    sel_d       = sel_q;
    place_idx_d = place_idx_q;
    place_d     = gate_acc;
    reject_d    = gate_req && game_active && !gate_acc;

    if (enableDC && gate_cd_q != CD_ZERO) gate_cd_d = gate_cd_q - CD_ONE;
    if (enableDC && bo_cd_q != CD_ZERO)   bo_cd_d   = bo_cd_q - CD_ONE;

    case (state_q)
      IDLE: begin
        if (bo_acc) begin
          state_d    = BLACKOUT;
          bo_timer_d = BO_LEN_V;
          bo_cd_d    = BO_CD_V;
        end
      end
      default: begin
        if (!game_active || (enableDC && bo_timer_q <= CD_ONE)) begin
          state_d    = IDLE;
          bo_timer_d = CD_ZERO;
        end else if (enableDC) begin
          bo_timer_d = bo_timer_q - CD_ONE;
        end
      end
    endcase

    if (gate_acc) begin
      gate_cd_d   = GATE_CD_V;
      place_idx_d = sel_q;
    end

    // Clear first so a same-cycle placement on the cleared slot survives.
    occ_d = occ_q & ~gate_clear;
    if (gate_acc) occ_d = occ_d | (NUM_GATES'(1) << sel_q);

    if (sel_next && !sel_back)
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + IDX_W'(1);
    else if (sel_back && !sel_next)
      sel_d = (sel_q == '0) ? SEL_MAX : sel_q - IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bo_timer_q  <= '0;
      gate_cd_q   <= '0;
      bo_cd_q     <= '0;
      sel_q       <= '0;
      occ_q       <= '0;
      place_q     <= 1'b0;
      place_idx_q <= '0;
      reject_q    <= 1'b0;
      bo_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bo_timer_q  <= bo_timer_d;
      gate_cd_q   <= gate_cd_d;
      bo_cd_q     <= bo_cd_d;
      sel_q       <= sel_d;
      occ_q       <= occ_d;
      place_q     <= place_d;
      place_idx_q <= place_idx_d;
      reject_q    <= reject_d;
      bo_active_q <= (state_d == BLACKOUT);
    end
  end

  assign sel_idx         = sel_q;
  assign gates_occupied  = occ_q;
  assign gate_place      = place_q;
  assign gate_place_idx  = place_idx_q;
  assign gate_reject     = reject_q;
  assign blackout_active = bo_active_q;
  assign gate_cd         = gate_cd_q;
  assign blackout_cd     = bo_cd_q;
  assign gate_ready      = (state_q == IDLE) && (gate_cd_q == CD_ZERO) && game_active;
  assign blackout_ready  = (state_q == IDLE) && (bo_cd_q == CD_ZERO) && game_active;

endmodule

// File: tb/tb_ability_scheduler.sv
// Table-driven bench for ability_scheduler: per-cycle vectors with expected
// post-edge outputs, queued when driven and compared after the clock edge.
module tb_ability_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enableDC, game_active, gate_req, blackout_req, sel_next, sel_back;
  logic [9:0] gate_clear;
  logic [3:0] sel_idx, gate_place_idx;
  logic [9:0] gates_occupied;
  logic       gate_place, gate_reject, blackout_active, gate_ready, blackout_ready;
  logic [4:0] gate_cd, blackout_cd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ability_scheduler dut (
    .clk(clk), .reset(reset), .enableDC(enableDC), .game_active(game_active),
    .gate_req(gate_req), .blackout_req(blackout_req), .sel_next(sel_next),
    .sel_back(sel_back), .gate_clear(gate_clear), .sel_idx(sel_idx),
    .gates_occupied(gates_occupied), .gate_place(gate_place),
    .gate_place_idx(gate_place_idx), .gate_reject(gate_reject),
    .blackout_active(blackout_active), .gate_ready(gate_ready),
    .blackout_ready(blackout_ready), .gate_cd(gate_cd), .blackout_cd(blackout_cd)
  );

  typedef struct {
    logic       ga, gr, br, sn, sb, tk;
    logic [9:0] clr;
    logic [3:0] e_sel;
    logic [9:0] e_occ;
    logic       e_gp;
    logic [3:0] e_gpi;
    logic       e_rej, e_ba;
    logic [4:0] e_gcd, e_bcd;
    logic       e_grdy, e_brdy;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic ga, gr, br, sn, sb, tk, input logic [9:0] clr,
                              input logic [3:0] sel, input logic [9:0] occ, input logic gp,
                              input logic [3:0] gpi, input logic rej, ba,
                              input logic [4:0] gcd, bcd, input logic grdy, brdy);
    vec_t v;
    v.ga = ga; v.gr = gr; v.br = br; v.sn = sn; v.sb = sb; v.tk = tk; v.clr = clr;
    v.e_sel = sel; v.e_occ = occ; v.e_gp = gp; v.e_gpi = gpi; v.e_rej = rej; v.e_ba = ba;
    v.e_gcd = gcd; v.e_bcd = bcd; v.e_grdy = grdy; v.e_brdy = brdy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, idx, act, req);
    end
  endtask

  task automatic idle_inputs();
    enableDC = 0; gate_req = 0; blackout_req = 0; sel_next = 0; sel_back = 0; gate_clear = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    game_active = v.ga; gate_req = v.gr; blackout_req = v.br; sel_next = v.sn;
    sel_back = v.sb; enableDC = v.tk; gate_clear = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sel_idx", idx, 32'(sel_idx), 32'(e.e_sel));
    chk("gates_occupied", idx, 32'(gates_occupied), 32'(e.e_occ));
    chk("gate_place", idx, 32'(gate_place), 32'(e.e_gp));
    if (e.e_gp) chk("gate_place_idx", idx, 32'(gate_place_idx), 32'(e.e_gpi));
    chk("gate_reject", idx, 32'(gate_reject), 32'(e.e_rej));
    chk("blackout_active", idx, 32'(blackout_active), 32'(e.e_ba));
    chk("gate_cd", idx, 32'(gate_cd), 32'(e.e_gcd));
    chk("blackout_cd", idx, 32'(blackout_cd), 32'(e.e_bcd));
    chk("gate_ready", idx, 32'(gate_ready), 32'(e.e_grdy));
    chk("blackout_ready", idx, 32'(blackout_ready), 32'(e.e_brdy));
    $display("vec %0d: ga=%0b gr=%0b br=%0b sn=%0b sb=%0b tk=%0b clr=%h -> sel=%0d occ=%h gp=%0b rej=%0b ba=%0b gcd=%0d bcd=%0d",
             idx, v.ga, v.gr, v.br, v.sn, v.sb, v.tk, v.clr, sel_idx, gates_occupied,
             gate_place, gate_reject, blackout_active, gate_cd, blackout_cd);
  endtask

  task automatic chk_reset_state(input int idx);
    chk("rst sel_idx", idx, 32'(sel_idx), 0);
    chk("rst gates_occupied", idx, 32'(gates_occupied), 0);
    chk("rst gate_place", idx, 32'(gate_place), 0);
    chk("rst gate_reject", idx, 32'(gate_reject), 0);
    chk("rst blackout_active", idx, 32'(blackout_active), 0);
    chk("rst gate_cd", idx, 32'(gate_cd), 0);
    chk("rst blackout_cd", idx, 32'(blackout_cd), 0);
    chk("rst gate_ready", idx, 32'(gate_ready), 32'(game_active));
    chk("rst blackout_ready", idx, 32'(blackout_ready), 32'(game_active));
  endtask

  initial begin
    // Main table: placement, cooldown, occupancy reject, selection wrap,
    // blackout pre-emption, blackout timing, clear/set collision, game inactive.
    tbl.push_back(mk(1,1,0,0,0,0,10'h000, 0,10'h001,1,0,0,0,7,0,0,1));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(1,0,0,0,0,1,10'h000, 0,10'h001,0,0,0,0,5'(6-k),0,(k==6),1));
    tbl.push_back(mk(1,1,0,0,0,0,10'h000, 0,10'h001,0,0,1,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,10'h000, 0,10'h001,0,0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,1,0,10'h000, 9,10'h001,0,0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,1,0,0,10'h000, 0,10'h001,0,0,0,0,0,0,1,1));
    for (int s = 1; s <= 4; s++)
      tbl.push_back(mk(1,0,0,1,0,0,10'h000, 4'(s),10'h001,0,0,0,0,0,0,1,1));
    tbl.push_back(mk(1,0,0,1,1,0,10'h000, 4,10'h001,0,0,0,0,0,0,1,1));
    tbl.push_back(mk(1,1,1,0,0,0,10'h000, 4,10'h001,0,0,1,1,0,30,0,0));
    tbl.push_back(mk(1,0,0,0,0,1,10'h000, 4,10'h001,0,0,0,1,0,29,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,10'h000, 4,10'h001,0,0,1,1,0,29,0,0));
    for (int j = 0; j < 4; j++)
      tbl.push_back(mk(1,0,0,0,0,1,10'h000, 4,10'h001,0,0,0,(j<3),0,5'(28-j),(j==3),0));
    tbl.push_back(mk(1,0,0,0,1,0,10'h000, 3,10'h001,0,0,0,0,0,25,1,0));
    tbl.push_back(mk(1,0,0,0,1,0,10'h000, 2,10'h001,0,0,0,0,0,25,1,0));
    tbl.push_back(mk(1,1,0,0,0,0,10'h004, 2,10'h005,1,2,0,0,7,25,0,0));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(1,0,0,0,0,1,10'h000, 2,10'h005,0,0,0,0,5'(6-k),5'(24-k),(k==6),0));
    tbl.push_back(mk(1,1,0,1,0,0,10'h000, 3,10'h005,0,0,1,0,0,18,1,0));
    tbl.push_back(mk(1,1,0,1,0,0,10'h000, 4,10'h00D,1,3,0,0,7,18,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,10'h001, 4,10'h00C,0,0,0,0,7,18,0,0));
    tbl.push_back(mk(0,1,0,0,0,1,10'h000, 4,10'h00C,0,0,0,0,6,17,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,10'h000, 4,10'h00C,0,0,0,0,6,17,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,10'h000, 4,10'h00C,0,0,0,0,6,17,0,0));

    idle_inputs();
    game_active = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state(-1);
    @(negedge clk);
    reset = 0;

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted mid-blackout with a gate placed and a cooldown running.
    apply(mk(1,0,0,0,0,0,10'h000, 4,10'h00C,0,0,0,0,6,17,0,0), 100);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    apply(mk(1,1,0,0,0,0,10'h000, 0,10'h001,1,0,0,0,7,0,0,1), 101);
    apply(mk(1,0,1,1,0,0,10'h000, 1,10'h001,0,0,0,1,7,30,0,0), 102);
    @(posedge clk);
    #2;
    idle_inputs();
    reset = 1;
    #1;
    chk_reset_state(103);
    @(negedge clk);
    reset = 0;

    // Blackout aborted the cycle after game_active drops; cooldown keeps its value.
    apply(mk(1,0,1,0,0,0,10'h000, 0,10'h000,0,0,0,1,0,30,0,0), 104);
    apply(mk(0,0,0,0,0,0,10'h000, 0,10'h000,0,0,0,0,0,30,0,0), 105);
    apply(mk(1,1,0,0,0,0,10'h000, 0,10'h001,1,0,0,0,7,30,0,0), 106);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
